// File: rtl/outstanding_req_limiter.sv
// Purpose : caps in-flight requests across NrChannels with a round-robin issue gate and a flush/drain FSM.
// Latency : zero-cycle combinational pass-through of valid/ready; count and flags update on the next edge.
// Backpress: only the granted channel sees downstream ready; no grant while full, draining, flushing or in reset.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   req_valid_i / req_ready_o    upstream request handshake per channel
//   req_valid_o / req_ready_i    downstream request handshake per channel
//   rsp_valid_i                  completion pulses per channel, always accepted
//   flush_i / flush_done_o       drain request and single-cycle completion pulse
//   outstanding_o, full_o, empty_o, err_o   registered count, derived flags, sticky underflow
module outstanding_req_limiter #(
    parameter int NrChannels     = 2,
    parameter int MaxOutstanding = 7,
    parameter int CntWidth       = $clog2(MaxOutstanding + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NrChannels-1:0] req_valid_i,
    output logic [NrChannels-1:0] req_ready_o,
    output logic [NrChannels-1:0] req_valid_o,
    input  logic [NrChannels-1:0] req_ready_i,
    input  logic [NrChannels-1:0] rsp_valid_i,
    input  logic                  flush_i,
    output logic                  flush_done_o,
    output logic [CntWidth-1:0]   outstanding_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  err_o
);

    localparam int PtrWidth  = (NrChannels > 1) ? $clog2(NrChannels) : 1;
    // Three guard bits: room for the +1 issue, up to four completions and a sign bit.
    localparam int WideWidth = CntWidth + 3;
    localparam logic [CntWidth-1:0]  MaxCnt  = CntWidth'(MaxOutstanding);
    localparam logic [WideWidth-1:0] MaxWide = WideWidth'(MaxOutstanding);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CntWidth-1:0]   count_q, count_d;
    logic [PtrWidth-1:0]   rr_ptr_q, rr_ptr_d;
    logic                  err_q, err_d;

    logic                  grant_en;
    logic [NrChannels-1:0] grant;
    logic [PtrWidth-1:0]   grant_idx;
    logic                  issue;
    logic [WideWidth-1:0]  rsp_cnt;
    logic [WideWidth-1:0]  next_wide;
    logic                  underflow;

    // Grants use the registered count only, so a same-cycle completion cannot
    // open a slot at full. flush_i closes the gate in the cycle it is raised.
    assign grant_en = (state_q == IDLE) && (count_q < MaxCnt) && !flush_i && !rst_i;

    // Round-robin search starting at rr_ptr_q; first requesting channel wins.
    always_comb begin : arbiter
        int   idx;
        logic found;
        idx       = 0;
        found     = 1'b0;
        grant     = '0;
        grant_idx = '0;
        for (int off = 0; off < NrChannels; off++) begin
            idx = (int'(rr_ptr_q) + off) % NrChannels;
            if (!found && req_valid_i[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = PtrWidth'(idx);
            end
        end
        if (!grant_en) begin
            grant = '0;
        end
    end

    assign req_valid_o = req_valid_i & grant;
    assign req_ready_o = req_ready_i & grant;
    assign issue       = |(req_valid_o & req_ready_i);

    // Pointer only advances on an accepted handshake, so a stalled grant keeps its turn.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (issue) begin
            rr_ptr_d = PtrWidth'((int'(grant_idx) + 1) % NrChannels);
        end
    end

    // Net issue and completions in one update; a negative result means more
    // completions than outstanding requests, which clamps to zero and latches err.
    always_comb begin
        rsp_cnt = '0;
        for (int i = 0; i < NrChannels; i++) begin
            rsp_cnt = rsp_cnt + WideWidth'(rsp_valid_i[i]);
        end
        next_wide = WideWidth'(count_q) + WideWidth'(issue) - rsp_cnt;
        underflow = next_wide[WideWidth-1];
        if (underflow) begin
            count_d = '0;
        end else if (next_wide > MaxWide) begin
            // Unreachable while the grant gate holds; keeps the counter bounded regardless.
            count_d = MaxCnt;
        end else begin
            count_d = next_wide[CntWidth-1:0];
        end
        err_d = err_q | underflow;
    end

    // Flush FSM. Looking at count_d lets an already-empty flush finish in one cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (flush_i) begin
                    state_d = (count_d == '0) ? DONE : DRAIN;
                end
            end
            DRAIN: begin
                if (count_d == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // A flush seen here is dropped, not queued.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            count_q  <= '0;
            rr_ptr_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            rr_ptr_q <= rr_ptr_d;
            err_q    <= err_d;
        end
    end

    assign flush_done_o  = (state_q == DONE);
    assign outstanding_o = count_q;
    assign full_o        = (count_q == MaxCnt);
    assign empty_o       = (count_q == '0);
    assign err_o         = err_q;

endmodule

// File: tb/tb_outstanding_req_limiter.sv
// Purpose : directed check of outstanding_req_limiter (2 channels, max 7) against hand-computed vectors.
// Latency : one vector per clock; expectations describe the cycle in which the vector is applied.
// Backpress: downstream ready driven per vector; the monitor samples on the falling edge.
module tb_outstanding_req_limiter;

    logic       clk;
    logic       rst;
    logic [1:0] req_valid_i;
    logic [1:0] req_ready_o;
    logic [1:0] req_valid_o;
    logic [1:0] req_ready_i;
    logic [1:0] rsp_valid_i;
    logic       flush_i;
    logic       flush_done_o;
    logic [2:0] outstanding_o;
    logic       full_o;
    logic       empty_o;
    logic       err_o;

    int checks = 0;
    int errors = 0;
    int step_id = 0;

    typedef struct {
        int         id;
        logic [1:0] vo;
        logic [1:0] ro;
        logic [2:0] cnt;
        logic       full;
        logic       empty;
        logic       err;
        logic       done;
    } exp_t;

    exp_t exp_q[$];

    outstanding_req_limiter #(
        .NrChannels    (2),
        .MaxOutstanding(7)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_valid_o  (req_valid_o),
        .req_ready_i  (req_ready_i),
        .rsp_valid_i  (rsp_valid_i),
        .flush_i      (flush_i),
        .flush_done_o (flush_done_o),
        .outstanding_o(outstanding_o),
        .full_o       (full_o),
        .empty_o      (empty_o),
        .err_o        (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string nm, input int id, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL step %0d %s: got %0h want %0h", id, nm, got, want);
        end
    endfunction

    // Monitor: every falling edge with a pending expectation pops and compares.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("req_valid_o",   e.id, {6'd0, req_valid_o},   {6'd0, e.vo});
            check("req_ready_o",   e.id, {6'd0, req_ready_o},   {6'd0, e.ro});
            check("outstanding_o", e.id, {5'd0, outstanding_o}, {5'd0, e.cnt});
            check("full_o",        e.id, {7'd0, full_o},        {7'd0, e.full});
            check("empty_o",       e.id, {7'd0, empty_o},       {7'd0, e.empty});
            check("err_o",         e.id, {7'd0, err_o},         {7'd0, e.err});
            check("flush_done_o",  e.id, {7'd0, flush_done_o},  {7'd0, e.done});
        end
    end

    // Apply one vector and queue what the DUT must show during this cycle.
    task automatic step(input logic [1:0] v, input logic [1:0] rdy, input logic [1:0] rsp,
                        input logic fl, input logic rs,
                        input logic [1:0] e_vo, input logic [2:0] e_cnt,
                        input logic e_err, input logic e_done);
        exp_t e;
        req_valid_i = v;
        req_ready_i = rdy;
        rsp_valid_i = rsp;
        flush_i     = fl;
        rst         = rs;
        step_id++;
        e.id    = step_id;
        e.vo    = e_vo;
        e.ro    = rdy & e_vo;
        e.cnt   = e_cnt;
        e.full  = (e_cnt == 3'd7);
        e.empty = (e_cnt == 3'd0);
        e.err   = e_err;
        e.done  = e_done;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        req_valid_i = '0;
        req_ready_i = '0;
        rsp_valid_i = '0;
        flush_i     = 1'b0;
        @(posedge clk);
        #1;

        //    valid  ready  rsp    fl rst   vo     cnt  err done
        // Reset held: outputs gated, count zero.
        step(2'b11, 2'b11, 2'b00, 0, 1,   2'b00, 3'd0, 0, 0);

        // Fill on ch0 to 7.
        for (int k = 0; k < 7; k++) begin
            step(2'b01, 2'b11, 2'b00, 0, 0, 2'b01, 3'(k), 0, 0);
        end
        // Full: completion in the same cycle does not unblock.
        step(2'b01, 2'b11, 2'b01, 0, 0,   2'b00, 3'd7, 0, 0);
        step(2'b00, 2'b11, 2'b00, 0, 0,   2'b00, 3'd6, 0, 0);

        // Round-robin with one completion per issue; pointer sits at ch1.
        step(2'b11, 2'b11, 2'b01, 0, 0,   2'b10, 3'd6, 0, 0);
        step(2'b11, 2'b11, 2'b01, 0, 0,   2'b01, 3'd6, 0, 0);
        step(2'b11, 2'b11, 2'b01, 0, 0,   2'b10, 3'd6, 0, 0);
        step(2'b11, 2'b11, 2'b01, 0, 0,   2'b01, 3'd6, 0, 0);
        // Grant held on ch1 while its downstream is not ready.
        step(2'b11, 2'b00, 2'b00, 0, 0,   2'b10, 3'd6, 0, 0);
        step(2'b11, 2'b01, 2'b00, 0, 0,   2'b10, 3'd6, 0, 0);
        step(2'b00, 2'b00, 2'b11, 0, 0,   2'b00, 3'd6, 0, 0);
        step(2'b00, 2'b00, 2'b01, 0, 0,   2'b00, 3'd4, 0, 0);

        // Net update: count 3, one issue, two completions.
        step(2'b01, 2'b11, 2'b11, 0, 0,   2'b01, 3'd3, 0, 0);
        step(2'b10, 2'b11, 2'b00, 0, 0,   2'b10, 3'd2, 0, 0);
        step(2'b10, 2'b11, 2'b00, 0, 0,   2'b10, 3'd3, 0, 0);

        // Drain from 4, one completion per cycle, flush ignored mid-drain and in DONE.
        step(2'b11, 2'b11, 2'b00, 1, 0,   2'b00, 3'd4, 0, 0);
        step(2'b11, 2'b11, 2'b01, 0, 0,   2'b00, 3'd4, 0, 0);
        step(2'b11, 2'b11, 2'b01, 1, 0,   2'b00, 3'd3, 0, 0);
        step(2'b11, 2'b11, 2'b01, 0, 0,   2'b00, 3'd2, 0, 0);
        step(2'b11, 2'b11, 2'b01, 0, 0,   2'b00, 3'd1, 0, 0);
        step(2'b11, 2'b11, 2'b00, 1, 0,   2'b00, 3'd0, 0, 1);
        step(2'b00, 2'b11, 2'b00, 0, 0,   2'b00, 3'd0, 0, 0);
        step(2'b00, 2'b00, 2'b00, 0, 0,   2'b00, 3'd0, 0, 0);

        // Flush at zero: done on the very next cycle.
        step(2'b11, 2'b11, 2'b00, 1, 0,   2'b00, 3'd0, 0, 0);
        step(2'b00, 2'b00, 2'b00, 0, 0,   2'b00, 3'd0, 0, 1);
        step(2'b00, 2'b00, 2'b00, 0, 0,   2'b00, 3'd0, 0, 0);

        // Underflow: count stays 0, err sticks through later traffic.
        step(2'b00, 2'b00, 2'b01, 0, 0,   2'b00, 3'd0, 0, 0);
        step(2'b01, 2'b11, 2'b00, 0, 0,   2'b01, 3'd0, 1, 0);
        step(2'b01, 2'b11, 2'b00, 0, 0,   2'b01, 3'd1, 1, 0);

        // Reset while draining at 2: no done pulse, then stale completion underflows.
        step(2'b00, 2'b00, 2'b00, 1, 0,   2'b00, 3'd2, 1, 0);
        step(2'b11, 2'b11, 2'b00, 0, 1,   2'b00, 3'd2, 1, 0);
        step(2'b00, 2'b00, 2'b00, 0, 0,   2'b00, 3'd0, 0, 0);
        step(2'b00, 2'b00, 2'b10, 0, 0,   2'b00, 3'd0, 0, 0);
        step(2'b11, 2'b11, 2'b00, 0, 0,   2'b01, 3'd0, 1, 0);
        step(2'b00, 2'b00, 2'b00, 0, 0,   2'b00, 3'd1, 1, 0);

        repeat (2) @(negedge clk);
        check("pending_expectations", step_id, 8'(exp_q.size()), 8'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
